// File: rtl/ospfb_capture_ctrl.sv
// ============================================================================
// ospfb_capture_ctrl : frame-aligned capture of FFT AXIS beats into a capture RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module ospfb_capture_ctrl #(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 2048,
  parameter int FRAMES  = 32,
  parameter int SAMP    = FRAMES * FFT_LEN,
  parameter int AWID    = $clog2(SAMP),
  parameter int FCW     = $clog2(FRAMES + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               arm,
  input  logic               abort,
  input  logic [2*WIDTH-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  output logic               ram_we,
  output logic [AWID-1:0]    ram_addr,
  output logic [2*WIDTH-1:0] ram_wdata,
  output logic               full,
  output logic               busy,
  output logic [FCW-1:0]     frame_cnt,
  output logic [7:0]         align_err_cnt
);

  localparam int SMPW = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 tready_q;
  logic [SMPW-1:0]      smp_q, smp_d;
  logic [AWID-1:0]      addr_q, addr_d;
  logic [FCW-1:0]       frame_q, frame_d;
  logic [7:0]           err_q, err_d;
  logic                 we_q, we_d;
  logic [AWID-1:0]      waddr_q, waddr_d;
  logic [2*WIDTH-1:0]   wdata_q, wdata_d;
  logic                 full_q, full_d;

  logic w_accept;
  logic w_smp_end;

  assign w_accept  = s_axis_tvalid & tready_q;
  assign w_smp_end = (smp_q == SMPW'(FFT_LEN - 1));

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    addr_d  = addr_q;
    frame_d = frame_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    // full trails the FULL state by one edge so it follows the final write
    full_d  = (state_q == ST_FULL) & ~arm & ~abort;

    if (abort) begin
      state_d = ST_IDLE;
      smp_d   = '0;
      addr_d  = '0;
      frame_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FULL: begin
          if (arm) begin
            state_d = ST_SYNC;
            smp_d   = '0;
            addr_d  = '0;
            frame_d = '0;
          end
        end
        ST_SYNC: begin
          if (w_accept && s_axis_tlast) begin
            state_d = ST_CAPTURE;
            smp_d   = '0;
            addr_d  = '0;
            frame_d = '0;
          end
        end
        ST_CAPTURE: begin
          if (w_accept) begin
            if (s_axis_tlast != w_smp_end) begin
              // an early tlast is itself a frame boundary, so capture restarts in place
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
              smp_d   = '0;
              addr_d  = '0;
              frame_d = '0;
              state_d = s_axis_tlast ? ST_CAPTURE : ST_SYNC;
            end else begin
              we_d    = 1'b1;
              waddr_d = addr_q;
              wdata_d = s_axis_tdata;
              addr_d  = addr_q + 1'b1;
              if (w_smp_end) begin
                smp_d   = '0;
                frame_d = frame_q + 1'b1;
              end else begin
                smp_d   = smp_q + 1'b1;
              end
              if (addr_q == AWID'(SAMP - 1)) state_d = ST_FULL;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      tready_q <= 1'b0;
      smp_q    <= '0;
      addr_q   <= '0;
      frame_q  <= '0;
      err_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= 1'b1;
      smp_q    <= smp_d;
      addr_q   <= addr_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      full_q   <= full_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign ram_we        = we_q;
  assign ram_addr      = waddr_q;
  assign ram_wdata     = wdata_q;
  assign full          = full_q;
  assign busy          = (state_q == ST_SYNC) || (state_q == ST_CAPTURE);
  assign frame_cnt     = frame_q;
  assign align_err_cnt = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ospfb_capture_ctrl.sv
// ============================================================================
// tb_ospfb_capture_ctrl : table, directed and randomized checks of the capture sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ospfb_capture_ctrl;

  localparam int WIDTH   = 16;
  localparam int FFT_LEN = 8;
  localparam int FRAMES  = 4;
  localparam int SAMP    = FRAMES * FFT_LEN;
  localparam int AWID    = $clog2(SAMP);
  localparam int FCW     = $clog2(FRAMES + 1);

  localparam int MD_IDLE = 0;
  localparam int MD_WAIT = 1;
  localparam int MD_CAP  = 2;
  localparam int MD_DONE = 3;

  logic               clk = 1'b0;
  logic               rstn;
  logic               arm, abort, tvalid, tlast;
  logic [2*WIDTH-1:0] tdata;
  logic               tready, ram_we, full, busy;
  logic [AWID-1:0]    ram_addr;
  logic [2*WIDTH-1:0] ram_wdata;
  logic [FCW-1:0]     frame_cnt;
  logic [7:0]         align_err_cnt;

  ospfb_capture_ctrl #(
    .WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .FRAMES(FRAMES)
  ) dut (
    .clk(clk), .rstn(rstn), .arm(arm), .abort(abort),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .full(full), .busy(busy),
    .frame_cnt(frame_cnt), .align_err_cnt(align_err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: capture progress is one beat position within the whole capture
  int m_mode, m_pos, m_err;
  bit m_ready;
  logic [2*WIDTH-1:0] act_img [SAMP];
  logic [2*WIDTH-1:0] img2    [SAMP];
  int wr_cnt;

  typedef struct {
    bit a; bit ab; bit v; bit l;
    bit e_busy; bit e_we; int e_addr;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = MD_IDLE;
    m_pos   = 0;
    m_err   = 0;
    m_ready = 1'b0;
  endtask

  task automatic step(input bit a, input bit ab, input bit v, input bit l,
                      input logic [2*WIDTH-1:0] d);
    bit e_we, e_full, e_busy, acc;
    int e_addr;
    logic [2*WIDTH-1:0] e_data;
    arm = a; abort = ab; tvalid = v; tlast = l; tdata = d;
    acc    = v && m_ready;
    e_we   = 1'b0;
    e_addr = 0;
    e_data = '0;
    e_full = (m_mode == MD_DONE) && !a && !ab;
    if (ab) begin
      m_mode = MD_IDLE;
      m_pos  = 0;
    end else if ((m_mode == MD_IDLE || m_mode == MD_DONE) && a) begin
      m_mode = MD_WAIT;
      m_pos  = 0;
    end else if (m_mode == MD_WAIT && acc && l) begin
      m_mode = MD_CAP;
      m_pos  = 0;
    end else if (m_mode == MD_CAP && acc) begin
      if (l != ((m_pos % FFT_LEN) == FFT_LEN - 1)) begin
        if (m_err < 255) m_err++;
        m_pos  = 0;
        m_mode = l ? MD_CAP : MD_WAIT;
      end else begin
        e_we   = 1'b1;
        e_addr = m_pos;
        e_data = d;
        m_pos++;
        if (m_pos == SAMP) m_mode = MD_DONE;
      end
    end
    e_busy  = (m_mode == MD_WAIT) || (m_mode == MD_CAP);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ram_we", ram_we, e_we);
    if (e_we) begin
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_data);
    end
    chk("status{full,busy,frame,err,tready}",
        {full, busy, frame_cnt, align_err_cnt, tready},
        {e_full, e_busy, FCW'(m_pos / FFT_LEN), 8'(m_err), 1'b1});
    if (ram_we) begin
      act_img[ram_addr] = ram_wdata;
      wr_cnt++;
    end
  endtask

  // kind 1: tlast early at smp 5 of frame bad_f; kind 2: tlast missing at smp 7 of frame bad_f
  task automatic send_frames(input int n, input int gap_pct, input int bad_f, input int kind);
    for (int f = 0; f < n; f++) begin
      int len;
      len = (f == bad_f && kind == 1) ? 6 : FFT_LEN;
      for (int s = 0; s < len; s++) begin
        bit l;
        while (int'($urandom_range(0, 99)) < gap_pct)
          step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
        l = (s == len - 1);
        if (f == bad_f && kind == 2 && s == FFT_LEN - 1) l = 1'b0;
        step(1'b0, 1'b0, 1'b1, l, {16'(f), 16'(s)});
      end
    end
  endtask

  task automatic reset_check(input string name);
    chk(name, {tready, ram_we, ram_addr, ram_wdata, full, busy, frame_cnt, align_err_cnt}, 64'd0);
  endtask

  initial begin
    int err0, nmis, g_s;
    tbl[0] = '{1, 0, 0, 0, 1, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 1, 0, 0};
    tbl[2] = '{0, 0, 1, 1, 1, 0, 0};
    tbl[3] = '{0, 0, 1, 0, 1, 1, 0};
    tbl[4] = '{0, 0, 1, 0, 1, 1, 1};
    tbl[5] = '{1, 0, 1, 0, 1, 1, 2};
    tbl[6] = '{1, 1, 1, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 1, 1, 0, 0, 0};
    tbl[8] = '{1, 0, 0, 0, 1, 0, 0};
    tbl[9] = '{0, 1, 0, 0, 0, 0, 0};

    rstn = 1'b0; arm = 0; abort = 0; tvalid = 0; tlast = 0; tdata = '0;
    wr_cnt = 0;
    model_reset();
    @(posedge clk); #1;
    reset_check("reset_outputs");
    rstn = 1'b1;
    step(0, 0, 0, 0, '0);
    chk("tready_after_release", tready, 1'b1);

    // Table: sync discard, capture start, arm ignored, abort beats arm, idle discard
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].a, tbl[i].ab, tbl[i].v, tbl[i].l, 32'hA000 + 32'(i));
      chk($sformatf("tbl[%0d].busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl[%0d].we", i), ram_we, tbl[i].e_we);
      if (tbl[i].e_we) chk($sformatf("tbl[%0d].addr", i), ram_addr, tbl[i].e_addr);
    end

    // Nominal contiguous capture
    wr_cnt = 0;
    step(1, 0, 0, 0, '0);
    send_frames(40, 0, -1, 0);
    chk("nominal_writes", wr_cnt, 32);
    chk("nominal_full", full, 1'b1);
    chk("nominal_frame_cnt", frame_cnt, 4);
    chk("nominal_err", align_err_cnt, 0);
    for (int i = 0; i < SAMP; i++) img2[i] = act_img[i];
    chk("nominal_img_word9", img2[9], {16'd2, 16'd1});

    // Arm from FULL clears full on the next edge; gapped recapture
    wr_cnt = 0;
    for (int i = 0; i < SAMP; i++) act_img[i] = 'x;
    step(1, 0, 0, 0, '0);
    chk("rearm_full_clear", full, 1'b0);
    send_frames(40, 50, -1, 0);
    nmis = 0;
    for (int i = 0; i < SAMP; i++) if (act_img[i] !== img2[i]) nmis++;
    chk("gapped_img_mismatches", nmis, 0);
    chk("gapped_writes", wr_cnt, 32);
    chk("gapped_full", full, 1'b1);

    // Early tlast at smp 5 of frame 1
    err0 = int'(align_err_cnt);
    wr_cnt = 0;
    step(1, 0, 0, 0, '0);
    send_frames(8, 0, 1, 1);
    chk("early_tlast_err", align_err_cnt, err0 + 1);
    chk("early_tlast_writes", wr_cnt, 5 + 32);
    chk("early_tlast_full", full, 1'b1);

    // Missing tlast at smp 7 of frame 1
    err0 = int'(align_err_cnt);
    wr_cnt = 0;
    step(1, 0, 0, 0, '0);
    send_frames(8, 0, 1, 2);
    chk("missing_tlast_err", align_err_cnt, err0 + 1);
    chk("missing_tlast_writes", wr_cnt, 7 + 32);
    chk("missing_tlast_full", full, 1'b1);

    // arm+abort collision mid-capture with a valid beat
    step(1, 0, 0, 0, '0);
    send_frames(2, 0, -1, 0);
    wr_cnt = 0;
    step(1, 1, 1, 0, 32'hDEAD);
    chk("collision_busy", busy, 1'b0);
    chk("collision_no_write", wr_cnt, 0);

    // Randomized traffic with occasional alignment faults, arms and aborts
    g_s = 0;
    for (int c = 0; c < 3000; c++) begin
      bit a, ab, v, l;
      a  = $urandom_range(0, 99) < 3;
      ab = $urandom_range(0, 99) < 1;
      v  = $urandom_range(0, 99) < 70;
      l  = $urandom_range(0, 1);
      if (v) begin
        l = (g_s == FFT_LEN - 1);
        if ($urandom_range(0, 99) < 3) l = !l;
        g_s = l ? 0 : (g_s + 1) % FFT_LEN;
      end
      step(a, ab, v, l, $urandom);
    end

    // Asynchronous reset in the middle of a capture
    step(1, 0, 0, 0, '0);
    send_frames(2, 0, -1, 0);
    #3 rstn = 1'b0;
    model_reset();
    #1;
    reset_check("midstream_reset_async");
    @(posedge clk); #1;
    reset_check("midstream_reset_held");
    rstn = 1'b1;
    step(0, 0, 1, 1, '0);
    chk("midstream_release_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
